fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 17 +
 rtl/fetch_skid_buffer.sv | 43 ++++
 rtl/fetch_unit.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg -- shared definitions for the instruction fetch stage.
//   fetch_state_e     : fetch controller states (BOOT is the reset state)
//   DEFAULT_RESET_PC  : first fetch address after reset
//   INSTR_BYTES       : PC increment per instruction
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        BOOT,
        FETCH,
        HOLD,
        DRAIN
    } fetch_state_e;

    localparam logic [31:0]  DEFAULT_RESET_PC = 32'h0000_1000;
    localparam int unsigned  INSTR_BYTES      = 4;

endpackage

// File: rtl/fetch_skid_buffer.sv
// fetch_skid_buffer -- one-entry buffer holding a fetched {pc, instruction}
// pair while the pipeline is stalled.
//   clk_i, rst_i      : clock, asynchronous active-high reset (empties buffer)
//   load_i            : capture pc_i/data_i and mark the entry valid
//   clear_i           : drop the entry (wins over load_i)
//   valid_o, pc_o, data_o : buffered entry; held while neither load nor clear
module fetch_skid_buffer #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            load_i,
    input  logic            clear_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] data_i,
    output logic            valid_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] data_o
);

    logic            valid_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] data_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            data_q  <= '0;
        end else if (clear_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            pc_q    <= pc_i;
            data_q  <= data_i;
        end
    end

    assign valid_o = valid_q;
    assign pc_o    = pc_q;
    assign data_o  = data_q;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit -- instruction fetch stage with stall skid buffer and branch
// redirect, driving the IF/ID pipeline register.
//   clk, reset                       : clock, asynchronous active-high reset
//   stall_in                         : load-use stall, freezes pc and IF/ID
//   branch_taken_in/branch_target_in : redirect from EX, flushes fetch
//   imem_req_out/imem_addr_out       : instruction-memory request
//   imem_ready_in/imem_data_in       : instruction-memory response
//   if_valid_out/if_pc_out/if_instr_out : IF/ID register contents
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall_in,
    input  logic            branch_taken_in,
    input  logic [XLEN-1:0] branch_target_in,
    output logic            imem_req_out,
    output logic [XLEN-1:0] imem_addr_out,
    input  logic            imem_ready_in,
    input  logic [XLEN-1:0] imem_data_in,
    output logic            if_valid_out,
    output logic [XLEN-1:0] if_pc_out,
    output logic [XLEN-1:0] if_instr_out
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] tgt_q, tgt_d;
    logic            req_q, req_d;
    logic            ifv_q, ifv_d;
    logic [XLEN-1:0] ifpc_q, ifpc_d;
    logic [XLEN-1:0] ifins_q, ifins_d;

    logic            skid_load, skid_clear, skid_valid;
    logic [XLEN-1:0] skid_pc, skid_data;
    logic [XLEN-1:0] pc_inc;

    assign pc_inc = pc_q + XLEN'(INSTR_BYTES);

    fetch_skid_buffer #(.XLEN(XLEN)) u_skid (
        .clk_i   (clk),
        .rst_i   (reset),
        .load_i  (skid_load),
        .clear_i (skid_clear),
        .pc_i    (pc_q),
        .data_i  (imem_data_in),
        .valid_o (skid_valid),
        .pc_o    (skid_pc),
        .data_o  (skid_data)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        tgt_d      = tgt_q;
        ifv_d      = ifv_q;
        ifpc_d     = ifpc_q;
        ifins_d    = ifins_q;
        skid_load  = 1'b0;
        skid_clear = 1'b0;

        // A redirect always kills the IF/ID entry and any buffered fetch.
        if (branch_taken_in) begin
            ifv_d      = 1'b0;
            skid_clear = 1'b1;
        end

        case (state_q)
            BOOT: begin
                state_d = FETCH;
                if (branch_taken_in) pc_d = branch_target_in;
            end
            FETCH: begin
                if (branch_taken_in) begin
                    if (imem_ready_in) begin
                        pc_d = branch_target_in;
                    end else begin
                        // Request already issued: let it complete in DRAIN.
                        tgt_d   = branch_target_in;
                        state_d = DRAIN;
                    end
                end else if (stall_in) begin
                    if (imem_ready_in) begin
                        skid_load = 1'b1;
                        state_d   = HOLD;
                    end
                end else if (imem_ready_in) begin
                    ifv_d   = 1'b1;
                    ifpc_d  = pc_q;
                    ifins_d = imem_data_in;
                    pc_d    = pc_inc;
                end else begin
                    ifv_d = 1'b0;
                end
            end
            HOLD: begin
                if (branch_taken_in) begin
                    pc_d    = branch_target_in;
                    state_d = FETCH;
                end else if (!stall_in) begin
                    ifv_d      = skid_valid;
                    ifpc_d     = skid_pc;
                    ifins_d    = skid_data;
                    pc_d       = pc_inc;
                    skid_clear = 1'b1;
                    state_d    = FETCH;
                end
            end
            DRAIN: begin
                if (branch_taken_in) tgt_d = branch_target_in;
                if (imem_ready_in) begin
                    // A branch arriving with the response is the newest target.
                    pc_d    = branch_taken_in ? branch_target_in : tgt_q;
                    state_d = FETCH;
                end
            end
            default: state_d = BOOT;
        endcase

        req_d = (state_d == FETCH) || (state_d == DRAIN);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            tgt_q   <= '0;
            req_q   <= 1'b0;
            ifv_q   <= 1'b0;
            ifpc_q  <= '0;
            ifins_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
            req_q   <= req_d;
            ifv_q   <= ifv_d;
            ifpc_q  <= ifpc_d;
            ifins_q <= ifins_d;
        end
    end

    // pc does not move while a request is outstanding, so it doubles as the
    // stable request address (including the old address in DRAIN).
    assign imem_req_out  = req_q;
    assign imem_addr_out = pc_q;
    assign if_valid_out  = ifv_q;
    assign if_pc_out     = ifpc_q;
    assign if_instr_out  = ifins_q;

endmodule
